// File: rtl/sdram_responder.sv
// -----------------------------------------------------------------------------
// sdram_responder
//   Target-side model of a single-data-rate SDRAM device. It decodes the
//   cs/ras/cas/we command bus, walks the power-up init sequence, tracks the
//   open row of each of the four banks and the CAS latency held in the mode
//   register. It serves single-word reads after CL cycles and byte-masked
//   writes from an internal 16-bit backing RAM.
//
//   Sticky error flags (cleared only by reset):
//     err_o[0] : READ/WRITE to a closed bank
//     err_o[1] : ACTIVE to a bank that is already open
//     err_o[2] : access before init complete, or illegal mode register value
//     err_o[3] : tRCD / tRP violation (timing checker builds only)
//
//   Optional feature macro: SDRAM_RESPONDER_TIMING_CHECK_EN
//     defined   -> per-bank cycle counters drive err_o[3]
//     undefined -> no counters are built, err_o[3] is constant 0
//
//   Command strobe handshake: there is no valid/ready pair. A command is
//   valid on any rising edge where cke_i=1 and cs_n_i=0, and the device is
//   always ready, so every valid command is consumed on the edge it is seen.
//   Read data is presented with dq_oe_o=1 for exactly one cycle.
// -----------------------------------------------------------------------------
module sdram_responder #(
   parameter int MEM_AW = 12,
   parameter int TRCD   = 3,
   parameter int TRP    = 3
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        cke_i,
   input  logic        cs_n_i,
   input  logic        ras_n_i,
   input  logic        cas_n_i,
   input  logic        we_n_i,
   input  logic [1:0]  bs_i,
   input  logic [11:0] a_i,
   input  logic [15:0] dq_i,
   input  logic [1:0]  dqm_i,
   output logic [15:0] dq_o,
   output logic        dq_oe_o,
   output logic        init_done_o,
   output logic [3:0]  err_o
);

   typedef enum logic [1:0] {
      INIT_WAIT = 2'd0,
      INIT_AR   = 2'd1,
      READY     = 2'd2
   } init_state_e;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_REF = 3'd5,
      CMD_MRS = 3'd6
   } cmd_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   init_state_e        state_q, state_d;
   logic [1:0]         ar_cnt_q, ar_cnt_d;      // saturates at 2 (enough refreshes)
   logic [2:0]         cl_q, cl_d;
   logic [3:0]         bank_open_q, bank_open_d;
   logic [3:0][11:0]   row_q, row_d;
   logic [3:0]         err_q, err_d;

   // Read return pipeline: a READ enters stage 3 (CL=3) or stage 2 (CL=2)
   // and the output register is loaded from stage 1.
   logic               p3_v_q, p3_v_d, p2_v_q, p2_v_d, p1_v_q, p1_v_d;
   logic [15:0]        p3_d_q, p3_d_d, p2_d_q, p2_d_d, p1_d_q, p1_d_d;
   logic [15:0]        dq_q, dq_d;
   logic               dq_oe_q, dq_oe_d;

   logic [15:0]        mem_q [0:(2**MEM_AW)-1];

   cmd_e               cmd;
   logic               ready;
   logic               rd_ok, wr_ok;
   logic               tchk_err;
   logic [21:0]        ram_idx;
   logic [MEM_AW-1:0]  mem_addr;
   logic [15:0]        rd_data;

   assign ready = (state_q == READY);

   // Command decode; a low cke_i or a deselected chip reads as NOP.
   always_comb begin
      cmd = CMD_NOP;
      if (cke_i && !cs_n_i) begin
         unique case ({ras_n_i, cas_n_i, we_n_i})
            3'b011:  cmd = CMD_ACT;
            3'b101:  cmd = CMD_RD;
            3'b100:  cmd = CMD_WR;
            3'b010:  cmd = CMD_PRE;
            3'b001:  cmd = CMD_REF;
            3'b000:  cmd = CMD_MRS;
            default: cmd = CMD_NOP;
         endcase
      end
   end

   // RAM word address: bank, open row and column, truncated to the RAM depth.
   always_comb begin
      ram_idx  = {bs_i, row_q[bs_i], a_i[7:0]};
      mem_addr = MEM_AW'(ram_idx);
      rd_data  = mem_q[mem_addr];
   end

   // Init FSM, mode register, bank tracking and error flags (next state).
   always_comb begin
      state_d     = state_q;
      ar_cnt_d    = ar_cnt_q;
      cl_d        = cl_q;
      bank_open_d = bank_open_q;
      row_d       = row_q;
      err_d       = err_q;
      rd_ok       = 1'b0;
      wr_ok       = 1'b0;

      unique case (cmd)
         CMD_MRS: begin
            // Only CL 2 and 3 are modelled; anything else keeps the old CL.
            if ((a_i[6:4] == 3'd2) || (a_i[6:4] == 3'd3)) begin
               cl_d = a_i[6:4];
            end else begin
               err_d[2] = 1'b1;
            end
            // Only burst length 1 is served.
            if (a_i[2:0] != 3'd0) begin
               err_d[2] = 1'b1;
            end
            if ((state_q == INIT_AR) && (ar_cnt_q == 2'd2)) begin
               state_d = READY;
            end
         end
         CMD_REF: begin
            if ((state_q == INIT_AR) && (ar_cnt_q != 2'd2)) begin
               ar_cnt_d = ar_cnt_q + 2'd1;
            end
         end
         CMD_PRE: begin
            if (a_i[10]) begin
               bank_open_d = '0;
            end else begin
               bank_open_d[bs_i] = 1'b0;
            end
            if (state_q == INIT_WAIT) begin
               state_d  = INIT_AR;
               ar_cnt_d = 2'd0;
            end
         end
         CMD_ACT: begin
            if (!ready) begin
               err_d[2] = 1'b1;
            end else begin
               if (bank_open_q[bs_i]) begin
                  err_d[1] = 1'b1;
               end
               bank_open_d[bs_i] = 1'b1;
               row_d[bs_i]       = a_i;
            end
         end
         CMD_RD, CMD_WR: begin
            if (!ready) begin
               err_d[2] = 1'b1;
            end else if (!bank_open_q[bs_i]) begin
               err_d[0] = 1'b1;
            end else begin
               rd_ok = (cmd == CMD_RD);
               wr_ok = (cmd == CMD_WR);
               // Auto-precharge closes the bank once the access is done.
               if (a_i[10]) begin
                  bank_open_d[bs_i] = 1'b0;
               end
            end
         end
         default: ;
      endcase

      err_d[3] = err_q[3] | tchk_err;
   end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
   // Cycles elapsed since the last ACTIVE/PRECHARGE of each bank.
   logic [3:0][3:0] tcnt_q, tcnt_d;

   // Timing counters: saturate at 15, restart on ACTIVE / PRECHARGE.
   // A command sampled k edges after the restart sees tcnt = k-1.
   always_comb begin
      tchk_err = 1'b0;
      for (int b = 0; b < 4; b++) begin
         tcnt_d[b] = (tcnt_q[b] == 4'd15) ? 4'd15 : tcnt_q[b] + 4'd1;
      end
      unique case (cmd)
         CMD_ACT: begin
            if (ready) begin
               if (int'(tcnt_q[bs_i]) + 1 < TRP) begin
                  tchk_err = 1'b1;
               end
               tcnt_d[bs_i] = 4'd0;
            end
         end
         CMD_PRE: begin
            if (a_i[10]) begin
               tcnt_d = '0;
            end else begin
               tcnt_d[bs_i] = 4'd0;
            end
         end
         CMD_RD, CMD_WR: begin
            if (ready && bank_open_q[bs_i]) begin
               if (int'(tcnt_q[bs_i]) + 1 < TRCD) begin
                  tchk_err = 1'b1;
               end
               if (a_i[10]) begin
                  tcnt_d[bs_i] = 4'd0;
               end
            end
         end
         default: ;
      endcase
   end

   // Timing counter registers; start saturated so the first ACTIVE is legal.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tcnt_q <= {4{4'd15}};
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign tchk_err = 1'b0;

   // The timing parameters have no consumer in this build.
   if ((TRCD < 0) || (TRP < 0)) begin : g_unused_timing_params
   end
`endif

   // Read pipeline and output register (next state).
   always_comb begin
      p3_v_d = 1'b0;
      p3_d_d = '0;
      p2_v_d = p3_v_q;
      p2_d_d = p3_d_q;
      p1_v_d = p2_v_q;
      p1_d_d = p2_d_q;
      if (rd_ok) begin
         if (cl_q == 3'd2) begin
            p2_v_d = 1'b1;
            p2_d_d = rd_data;
         end else begin
            p3_v_d = 1'b1;
            p3_d_d = rd_data;
         end
      end
      dq_oe_d = p1_v_q;
      dq_d    = p1_v_q ? p1_d_q : 16'h0000;
   end

   // Control, pipeline and output registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= INIT_WAIT;
         ar_cnt_q    <= 2'd0;
         cl_q        <= 3'd3;
         bank_open_q <= '0;
         row_q       <= '0;
         err_q       <= '0;
         p3_v_q      <= 1'b0;
         p3_d_q      <= '0;
         p2_v_q      <= 1'b0;
         p2_d_q      <= '0;
         p1_v_q      <= 1'b0;
         p1_d_q      <= '0;
         dq_q        <= '0;
         dq_oe_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ar_cnt_q    <= ar_cnt_d;
         cl_q        <= cl_d;
         bank_open_q <= bank_open_d;
         row_q       <= row_d;
         err_q       <= err_d;
         p3_v_q      <= p3_v_d;
         p3_d_q      <= p3_d_d;
         p2_v_q      <= p2_v_d;
         p2_d_q      <= p2_d_d;
         p1_v_q      <= p1_v_d;
         p1_d_q      <= p1_d_d;
         dq_q        <= dq_d;
         dq_oe_q     <= dq_oe_d;
      end
   end

   // Backing RAM write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         if (!dqm_i[1]) begin
            mem_q[mem_addr][15:8] <= dq_i[15:8];
         end
         if (!dqm_i[0]) begin
            mem_q[mem_addr][7:0] <= dq_i[7:0];
         end
      end
   end

   assign dq_o        = dq_q;
   assign dq_oe_o     = dq_oe_q;
   assign init_done_o = ready;
   assign err_o       = err_q;

endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable SDR SDRAM device responder on the target side of the controller's command bus.
- Decodes cs/ras/cas/we commands and tracks per-bank open-row state and the mode register.
- Serves single-word reads after CAS latency and byte-masked writes from an internal backing RAM.
- Used in benches and in on-FPGA loopback builds in place of the physical chip; raises sticky protocol-error flags.

Parameters:
- MEM_AW, 12: backing RAM address width; depth 2^MEM_AW words of 16 bits.
- TRCD, 3: minimum cycles from ACTIVE to READ/WRITE on the same bank (timing-check feature only).
- TRP, 3: minimum cycles from PRECHARGE to ACTIVE on the same bank (timing-check feature only).

Ports:
- clk_i  in  1  clock; all sampling on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- cke_i  in  1  clock enable; low = command treated as NOP.
- cs_n_i, ras_n_i, cas_n_i, we_n_i  in  1 each  command strobes.
- bs_i  in  2  bank select.
- a_i  in  12  row / column / mode address.
- dq_i  in  16  write data.
- dqm_i  in  2  write byte mask; bit1 = dq[15:8], bit0 = dq[7:0]; 1 = masked.
- dq_o  out  16  read data.
- dq_oe_o  out  1  read data valid / drive enable.
- init_done_o  out  1  initialisation sequence complete.
- err_o  out  4  sticky error flags.

Behaviour:
- Command decode, {cs,ras,cas,we}, only when cke_i=1:
  - cs=1: DESELECT.
  - 0111: NOP. 0011: ACTIVE. 0101: READ. 0100: WRITE.
  - 0010: PRECHARGE. 0001: AUTO_REFRESH. 0000: MODE_REG_SET.
- Reset values: all banks closed, CL=3, refresh count 0, init_done_o=0, dq_o=0, dq_oe_o=0, err_o=0. RAM contents are not reset.
- Init state machine, states INIT_WAIT, INIT_AR, READY:
  - INIT_WAIT: accepts PRECHARGE, then moves to INIT_AR.
  - INIT_AR: counts AUTO_REFRESH commands. MODE_REG_SET after at least 2 of them moves to READY and sets init_done_o on the next cycle.
  - Before READY: ACTIVE, READ or WRITE sets err_o[2] and the command is ignored.
- MODE_REG_SET:
  - CL = a_i[6:4]. Values 2 and 3 are legal; any other value sets err_o[2] and keeps the previous CL.
  - a_i[2:0] != 0 (burst length other than 1) sets err_o[2].
  - Accepted in READY as well; re-programs CL.
- ACTIVE:
  - Stores the row a_i for bank bs_i and marks the bank open.
  - ACTIVE to an already-open bank sets err_o[1] and overwrites the row.
- PRECHARGE: a_i[10]=1 closes all banks; otherwise closes bank bs_i. Closing an already-closed bank is legal.
- AUTO_REFRESH in READY: no effect.
- RAM index: {bs_i, open_row[bs_i], a_i[7:0]}, 22 bits, truncated to the low MEM_AW bits.
- READ:
  - Bank closed: err_o[0] set, no data returned.
  - Bank open: the RAM word is fetched at the command edge and pushed into a CL-deep pipeline.
  - dq_o/dq_oe_o valid for exactly one cycle, CL rising edges after the edge that sampled READ. For CL=3, READ sampled at edge N gives dq_oe_o=1 after edge N+3.
  - When dq_oe_o=0, dq_o holds 0.
- WRITE:
  - Bank closed: err_o[0] set, RAM unchanged.
  - Bank open: byte lanes with dqm_i bit = 0 are written at the command edge.
- Auto-precharge: a_i[10]=1 on READ or WRITE closes the bank after the access.
- Back-to-back and simultaneous events:
  - READs may be issued every cycle; the pipeline holds up to CL reads in flight.
  - A WRITE to the same address as an in-flight READ does not alter the returned data, because the fetch happened at the READ edge.
- cke_i=0: command decode is frozen; the read pipeline keeps advancing.
- Reset asserted mid-operation: in-flight reads are discarded, dq_oe_o=0 immediately (asynchronous), and the init sequence must be repeated.
- err_o bits are sticky until reset.

Optional Feature:
- Macro: SDRAM_RESPONDER_TIMING_CHECK_EN.
- Defined:
  - Each bank has a cycle counter, saturating at 15 and cleared on ACTIVE or PRECHARGE of that bank.
  - READ or WRITE with counter < TRCD since ACTIVE sets err_o[3].
  - ACTIVE with counter < TRP since PRECHARGE sets err_o[3].
  - A PRECHARGE-all command clears all bank counters.
- Undefined: no counters are built and err_o[3] is tied to 0.

Test Plan:
- Init sequence: reset, PRECHARGE a[10]=1, 2x AUTO_REFRESH, MRS a=12'h030 -> init_done_o=1 one cycle after MRS, CL=3, err_o=0.
- Write then read: ACTIVE bs=1 row=12'h005; WRITE col=8'h12 dq=16'hBEEF dqm=0 a[10]=0; READ col=8'h12 -> dq_oe_o=1 with dq_o=16'hBEEF exactly 3 edges after the READ edge.
- Byte mask: WRITE 16'h1234 dqm=2'b10 over existing 16'hBEEF -> subsequent READ returns 16'hBE34.
- CL=2: MRS a=12'h020, READ -> data valid 2 edges after the READ edge; 4 back-to-back READs -> 4 consecutive valid cycles in issue order.
- Protocol errors: READ to closed bank -> err_o[0]=1, no dq_oe_o; ACTIVE twice on bank 0 -> err_o[1]=1; ACTIVE before init -> err_o[2]=1.
- Timing check (macro defined): ACTIVE then READ 1 cycle later with TRCD=3 -> err_o[3]=1; same sequence with the macro undefined -> err_o[3]=0 and data still returned.
